// File: rtl/host_if_queued.sv
// rtl/host_if_queued.sv - OPL3 host bus interface with queued, spaced register writes
//
// Decodes host chip-select/strobe accesses into address-latch writes, data writes
// (queued in a first-word-fall-through FIFO), status reads and diagnostic reads.
// Queued writes drain to the register file over a valid/ready port, with a
// programmable minimum number of clocks between successive transfers.
//
// Ports:
//   clk           rising-edge clock for all logic
//   ic_n          synchronous active-low reset
//   cs_n/rd_n/wr_n host strobes, active low, already synchronous to clk
//   address       bit 0 selects address/status (0) or data/diagnostic (1) port,
//                 bits [BANK_W:1] select the register bank
//   din           host write data
//   dout          registered host read data
//   status        chip status word returned by a status read
//   reg_wr_*      head-of-queue register write and its handshake
//   fifo_level    queue occupancy, 0..FIFO_DEPTH
//   overflow      sticky flag, set when a data write found the queue full
module host_if_queued #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_BANKS     = 2,
  parameter int FIFO_DEPTH    = 16,
  parameter int WRITE_SPACING = 4,
  localparam int BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  ic_n,
  input  logic                  cs_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic [BANK_W:0]       address,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic [DATA_WIDTH-1:0] status,
  output logic                  reg_wr_valid,
  input  logic                  reg_wr_ready,
  output logic [BANK_W-1:0]     reg_bank,
  output logic [DATA_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_data,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = (WRITE_SPACING > 1) ? $clog2(WRITE_SPACING) : 1;
  localparam int ENTRY_W = BANK_W + 2 * DATA_WIDTH;

  // Registered host inputs; strobes idle high out of reset so a cs_n held low
  // across reset release still produces exactly one access.
  logic                  r_cs_n;
  logic                  r_cs_n_d;
  logic                  r_rd_n;
  logic                  r_wr_n;
  logic [BANK_W:0]       r_address;
  logic [DATA_WIDTH-1:0] r_din;

  // Address latch shared by all following data writes.
  logic [BANK_W-1:0]     r_bank;
  logic [DATA_WIDTH-1:0] r_addr;

  logic [ENTRY_W-1:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_dout;

  logic                  w_access;
  logic                  w_is_wr;
  logic                  w_is_rd;
  logic                  w_port;
  logic [BANK_W-1:0]     w_bank_in;
  logic                  w_bank_ok;
  logic                  w_addr_wr;
  logic                  w_data_wr;
  logic                  w_stat_rd;
  logic                  w_diag_rd;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic [ENTRY_W-1:0]    w_head;
  logic [DATA_WIDTH-1:0] w_diag;

  always_ff @(posedge clk) begin
    if (!ic_n) begin
      r_cs_n    <= 1'b1;
      r_cs_n_d  <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_address <= '0;
      r_din     <= '0;
    end else begin
      r_cs_n    <= cs_n;
      r_cs_n_d  <= r_cs_n;
      r_rd_n    <= rd_n;
      r_wr_n    <= wr_n;
      r_address <= address;
      r_din     <= din;
    end
  end

  // One access per cs_n low period: only its first registered low cycle counts.
  assign w_access  = !r_cs_n && r_cs_n_d;
  assign w_is_wr   = w_access && !r_wr_n && r_rd_n;
  assign w_is_rd   = w_access && !r_rd_n && r_wr_n;
  assign w_port    = r_address[0];
  assign w_bank_in = r_address[BANK_W:1];
  assign w_bank_ok = {1'b0, w_bank_in} < (BANK_W + 1)'(NUM_BANKS);
  assign w_addr_wr = w_is_wr && !w_port;
  assign w_data_wr = w_is_wr && w_port;
  assign w_stat_rd = w_is_rd && !w_port;
  assign w_diag_rd = w_is_rd && w_port;

  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  // Fullness is judged before any same-cycle pop, so a push into a full
  // queue is dropped even while the head is leaving.
  assign w_push  = w_data_wr && !w_full;
  assign w_valid = !w_empty && (r_cnt == '0);
  assign w_pop   = w_valid && reg_wr_ready;
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    w_diag                               = '0;
    w_diag[DATA_WIDTH-1]                 = r_overflow;
    w_diag[DATA_WIDTH-2]                 = w_full;
    w_diag[DATA_WIDTH-3 -: LVL_W]        = r_level;
  end

  always_ff @(posedge clk) begin
    if (!ic_n) begin
      r_bank <= '0;
      r_addr <= '0;
    end else if (w_addr_wr && w_bank_ok) begin
      r_bank <= w_bank_in;
      r_addr <= r_din;
    end
  end

  always_ff @(posedge clk) begin
    if (ic_n && w_push) begin
      r_mem[r_wr_ptr] <= {r_bank, r_addr, r_din};
    end
  end

  always_ff @(posedge clk) begin
    if (!ic_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Spacing counter runs only after a transfer; zero means the port may fire.
  always_ff @(posedge clk) begin
    if (!ic_n) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= CNT_W'(WRITE_SPACING - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // A drop in the same cycle as a diagnostic read keeps the flag set.
  always_ff @(posedge clk) begin
    if (!ic_n) begin
      r_overflow <= 1'b0;
    end else if (w_data_wr && w_full) begin
      r_overflow <= 1'b1;
    end else if (w_diag_rd) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!ic_n) begin
      r_dout <= '0;
    end else if (w_stat_rd) begin
      r_dout <= status;
    end else if (w_diag_rd) begin
      r_dout <= w_diag;
    end
  end

  assign dout         = r_dout;
  assign reg_wr_valid = w_valid;
  assign reg_bank     = w_head[ENTRY_W-1 -: BANK_W];
  assign reg_addr     = w_head[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign reg_data     = w_head[DATA_WIDTH-1:0];
  assign fifo_level   = r_level;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_host_if_queued.sv
// tb/tb_host_if_queued.sv - self-checking bench for host_if_queued
module tb_host_if_queued;

  localparam int DW    = 8;
  localparam int NB    = 3;
  localparam int DEPTH = 16;
  localparam int SP    = 4;
  localparam int BW    = 2;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          ic_n;
  logic          cs_n;
  logic          rd_n;
  logic          wr_n;
  logic [BW:0]   address;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic [DW-1:0] status;
  logic          reg_wr_valid;
  logic          reg_wr_ready;
  logic [BW-1:0] reg_bank;
  logic [DW-1:0] reg_addr;
  logic [DW-1:0] reg_data;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  always #5 clk = ~clk;

  host_if_queued #(
    .DATA_WIDTH(DW), .NUM_BANKS(NB), .FIFO_DEPTH(DEPTH), .WRITE_SPACING(SP)
  ) dut (
    .clk(clk), .ic_n(ic_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .address(address), .din(din), .dout(dout), .status(status),
    .reg_wr_valid(reg_wr_valid), .reg_wr_ready(reg_wr_ready),
    .reg_bank(reg_bank), .reg_addr(reg_addr), .reg_data(reg_data),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  typedef struct packed {
    logic [BW-1:0] bank;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t exp_q[$];
  entry_t got_q[$];
  int     got_cyc[$];
  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;

  logic [BW-1:0] m_bank;
  logic [DW-1:0] m_addr;
  bit            m_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every handshake that will complete at the coming rising edge.
  always @(negedge clk) begin
    #2;
    if (ic_n && reg_wr_valid && reg_wr_ready) begin
      entry_t e;
      e.bank = reg_bank;
      e.addr = reg_addr;
      e.data = reg_data;
      got_q.push_back(e);
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [DW-1:0] diag_val(input bit o, input int lvl);
    diag_val = {o, (lvl == DEPTH), LW'(lvl), 1'b0};
  endfunction

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic host_access(input logic r, input logic w, input logic [BW:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    cs_n = 1'b0; rd_n = r; wr_n = w; address = a; din = d;
    @(negedge clk);
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic addr_write(input logic [BW-1:0] b, input logic [DW-1:0] a);
    host_access(1'b1, 1'b0, {b, 1'b0}, a);
    if (int'(b) < NB) begin
      m_bank = b;
      m_addr = a;
    end
  endtask

  task automatic data_write(input logic [DW-1:0] d);
    entry_t e;
    e.bank = m_bank; e.addr = m_addr; e.data = d;
    if (exp_q.size() - got_q.size() < DEPTH) exp_q.push_back(e);
    else m_ovf = 1'b1;
    host_access(1'b1, 1'b0, {BW'($urandom), 1'b1}, d);
  endtask

  task automatic wait_drain(input int n, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (got_q.size() >= n) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    ic_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    address = '0; din = '0; status = '0; reg_wr_ready = 1'b0;
    m_bank = '0; m_addr = '0; m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%h exp=00", dout); end
    n_tests++; if (reg_wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", reg_wr_valid); end
    n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    ic_n = 1'b1;
    clear_model();
  endtask

  task automatic test_single();
    bit to;
    clear_model();
    reg_wr_ready = 1'b1;
    addr_write(2'd1, 8'hB0);
    data_write(8'h2A);
    @(negedge clk);
    n_tests++; if (reg_wr_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_latency got=%b exp=1", reg_wr_valid); end
    wait_drain(1, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL single_timeout got=%0d exp=1 transfers", got_q.size()); end
    repeat (8) @(negedge clk);
    n_tests++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_tests++;
      if (got_q[0] !== {2'd1, 8'hB0, 8'h2A}) begin
        n_fail++; $display("FAIL single_entry got=%h exp=%h", got_q[0], {2'd1, 8'hB0, 8'h2A});
      end
    end
    n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL single_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_spacing();
    bit to;
    clear_model();
    reg_wr_ready = 1'b1;
    addr_write(BW'($urandom_range(0, NB - 1)), DW'($urandom));
    for (int i = 0; i < 5; i++) data_write(DW'($urandom));
    wait_drain(5, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL spacing_timeout got=%0d exp=5 transfers", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL spacing_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      if (i > 0) begin
        n_tests++;
        if (got_cyc[i] - got_cyc[i-1] !== SP) begin
          n_fail++; $display("FAIL spacing_gap%0d got=%0d exp=%0d", i, got_cyc[i] - got_cyc[i-1], SP);
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit to;
    clear_model();
    reg_wr_ready = 1'b0;
    m_ovf = 1'b0;
    addr_write(BW'($urandom_range(0, NB - 1)), DW'($urandom));
    for (int i = 0; i < DEPTH + 2; i++) data_write(DW'($urandom));
    @(negedge clk);
    n_tests++; if (fifo_level !== LW'(DEPTH)) begin n_fail++; $display("FAIL ovf_level got=%0d exp=%0d", fifo_level, DEPTH); end
    n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL ovf_flag got=%b exp=%b", overflow, m_ovf); end
    host_access(1'b0, 1'b1, 3'b001, 8'h00);
    @(negedge clk);
    n_tests++;
    if (dout !== diag_val(m_ovf, exp_q.size())) begin
      n_fail++; $display("FAIL ovf_diag1 got=%h exp=%h", dout, diag_val(m_ovf, exp_q.size()));
    end
    m_ovf = 1'b0;
    host_access(1'b0, 1'b1, 3'b101, 8'h00);
    @(negedge clk);
    n_tests++;
    if (dout !== diag_val(m_ovf, exp_q.size())) begin
      n_fail++; $display("FAIL ovf_diag2 got=%h exp=%h", dout, diag_val(m_ovf, exp_q.size()));
    end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared got=%b exp=0", overflow); end
    reg_wr_ready = 1'b1;
    wait_drain(DEPTH, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL ovf_timeout got=%0d exp=%0d transfers", got_q.size(), DEPTH); end
    repeat (10) @(negedge clk);
    n_tests++; if (got_q.size() !== DEPTH) begin n_fail++; $display("FAIL ovf_drain_count got=%0d exp=%0d", got_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL ovf_final_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_simul();
    bit to;
    entry_t e;
    logic [DW-1:0] d;
    clear_model();
    reg_wr_ready = 1'b0;
    addr_write(BW'($urandom_range(0, NB - 1)), DW'($urandom));
    for (int i = 0; i < 3; i++) data_write(DW'($urandom));
    @(negedge clk);
    n_tests++; if (fifo_level !== LW'(3)) begin n_fail++; $display("FAIL simul_level_pre got=%0d exp=3", fifo_level); end
    d = DW'($urandom);
    e.bank = m_bank; e.addr = m_addr; e.data = d;
    exp_q.push_back(e);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; address = 3'b001; din = d;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    reg_wr_ready = 1'b1;
    @(negedge clk);
    reg_wr_ready = 1'b0;
    n_tests++; if (fifo_level !== LW'(3)) begin n_fail++; $display("FAIL simul_level got=%0d exp=3", fifo_level); end
    n_tests++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL simul_pop_count got=%0d exp=1", got_q.size()); end
    reg_wr_ready = 1'b1;
    wait_drain(4, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL simul_timeout got=%0d exp=4 transfers", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL simul_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bank_ignore();
    bit to;
    clear_model();
    reg_wr_ready = 1'b1;
    addr_write(2'd2, 8'h55);
    addr_write(2'd3, 8'h77);
    data_write(8'h11);
    status = 8'h3C;
    host_access(1'b0, 1'b1, 3'b000, 8'h00);
    @(negedge clk);
    n_tests++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL ign_status got=%h exp=3c", dout); end
    status = 8'h5A;
    host_access(1'b0, 1'b0, 3'b010, 8'h99);
    host_access(1'b0, 1'b0, 3'b011, 8'h98);
    @(negedge clk);
    n_tests++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL ign_both_low_dout got=%h exp=3c", dout); end
    data_write(8'h22);
    wait_drain(2, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL ign_timeout got=%0d exp=2 transfers", got_q.size()); end
    repeat (8) @(negedge clk);
    n_tests++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL ign_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ign_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit to;
    int op;
    clear_model();
    for (int n = 0; n < 60; n++) begin
      reg_wr_ready = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 3);
      if (op == 0) begin
        addr_write(BW'($urandom_range(0, 3)), DW'($urandom));
      end else if (op == 3) begin
        status = DW'($urandom);
        host_access(1'b0, 1'b1, {BW'($urandom), 1'b0}, DW'($urandom));
        @(negedge clk);
        n_tests++; if (dout !== status) begin n_fail++; $display("FAIL rand_status%0d got=%h exp=%h", n, dout, status); end
      end else if (exp_q.size() - got_q.size() < DEPTH - 4) begin
        data_write(DW'($urandom));
      end
    end
    reg_wr_ready = 1'b1;
    wait_drain(exp_q.size(), to);
    n_tests++; if (to) begin n_fail++; $display("FAIL rand_timeout got=%0d exp=%0d transfers", got_q.size(), exp_q.size()); end
    repeat (8) @(negedge clk);
    n_tests++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_flush();
    bit to;
    clear_model();
    reg_wr_ready = 1'b0;
    status = 8'h99;
    host_access(1'b0, 1'b1, 3'b000, 8'h00);
    addr_write(2'd1, 8'h44);
    for (int i = 0; i < 5; i++) data_write(DW'($urandom));
    @(negedge clk);
    n_tests++; if (fifo_level !== LW'(5)) begin n_fail++; $display("FAIL flush_level_pre got=%0d exp=5", fifo_level); end
    ic_n = 1'b0;
    @(negedge clk);
    n_tests++; if (reg_wr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", reg_wr_valid); end
    n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL flush_level got=%0d exp=0", fifo_level); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_overflow got=%b exp=0", overflow); end
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL flush_dout got=%h exp=00", dout); end
    ic_n = 1'b1;
    clear_model();
    m_bank = '0; m_addr = '0; m_ovf = 1'b0;
    status = 8'hC0;
    host_access(1'b0, 1'b1, 3'b000, 8'h00);
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL stat_early got=%h exp=00", dout); end
    @(negedge clk);
    n_tests++; if (dout !== 8'hC0) begin n_fail++; $display("FAIL stat_read got=%h exp=c0", dout); end
    reg_wr_ready = 1'b1;
    data_write(8'h5E);
    wait_drain(1, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL flush_timeout got=%0d exp=1 transfers", got_q.size()); end
    repeat (10) @(negedge clk);
    n_tests++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL flush_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_tests++;
      if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL flush_entry got=%h exp=%h", got_q[0], exp_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_spacing();
    test_overflow();
    test_simul();
    test_bank_ignore();
    test_random();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
